// File: rtl/bias_relu_requant_pkg.sv
// Shared arithmetic for post-accumulation stages: lane slicing and the
// round-half-up / saturate sequence every layer uses identically.
package bias_relu_requant_pkg;

    localparam int IN_W_DEF   = 18;
    localparam int BIAS_W_DEF = 18;
    localparam int OUT_W_DEF  = 16;

    function automatic int lane_lsb(input int width, input int idx);
        return width * idx;
    endfunction

    function automatic int sum_width(input int a_w, input int b_w);
        return ((a_w > b_w) ? a_w : b_w) + 1;
    endfunction

    // Arithmetic right shift with a half-LSB added first (round half up).
    function automatic logic signed [31:0] rq_round(input logic signed [31:0] s,
                                                    input int shift);
        if (shift > 0) begin
            return (s + (32'sd1 <<< (shift - 1))) >>> shift;
        end else begin
            return s;
        end
    endfunction

    function automatic logic signed [31:0] rq_max(input int out_w);
        return (32'sd1 <<< (out_w - 1)) - 32'sd1;
    endfunction

    function automatic logic signed [31:0] rq_min(input int out_w);
        return -(32'sd1 <<< (out_w - 1));
    endfunction

    function automatic logic rq_is_sat(input logic signed [31:0] r, input int out_w);
        return (r > rq_max(out_w)) || (r < rq_min(out_w));
    endfunction

    function automatic logic signed [31:0] rq_sat(input logic signed [31:0] r,
                                                  input int out_w);
        if (r > rq_max(out_w)) begin
            return rq_max(out_w);
        end else if (r < rq_min(out_w)) begin
            return rq_min(out_w);
        end else begin
            return r;
        end
    endfunction

endpackage

// File: rtl/requant_lane.sv
// One channel lane: bias add (feeds stage 1) and ReLU/round/saturate
// (feeds stage 2). Purely combinational; the pipeline registers live in the top.
module requant_lane
    import bias_relu_requant_pkg::*;
#(
    parameter int IN_W    = IN_W_DEF,
    parameter int BIAS_W  = BIAS_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int SHIFT   = 2,
    parameter int RELU_EN = 1,
    parameter int SUM_W   = sum_width(IN_W, BIAS_W)
)(
    input  logic [IN_W-1:0]   in_word,
    input  logic [BIAS_W-1:0] bias_word,
    output logic [SUM_W-1:0]  sum,
    input  logic [SUM_W-1:0]  sum_q,
    output logic [OUT_W-1:0]  q,
    output logic              sat
);

    logic signed [31:0] s_ext_s;
    logic signed [31:0] s_relu_s;
    logic signed [31:0] r_s;

    // Sign-extended bias add; one extra bit means it can never overflow.
    always_comb begin
        sum = SUM_W'(signed'(in_word)) + SUM_W'(signed'(bias_word));
    end

    // ReLU, rounding shift and saturation of the registered sum.
    always_comb begin
        s_ext_s  = 32'(signed'(sum_q));
        s_relu_s = ((RELU_EN != 32'sd0) && (s_ext_s < 32'sd0)) ? 32'sd0 : s_ext_s;
        r_s      = rq_round(s_relu_s, SHIFT);
        q        = OUT_W'(rq_sat(r_s, OUT_W));
        sat      = rq_is_sat(r_s, OUT_W);
    end

endmodule

// File: rtl/bias_relu_requant.sv
// Two-stage valid/ready pipeline: bias add, then ReLU/round/saturate per lane,
// with a feature-map beat counter and a sticky saturation flag.
module bias_relu_requant
    import bias_relu_requant_pkg::*;
#(
    parameter int N_adder_tree = 16,
    parameter int IN_W         = IN_W_DEF,
    parameter int BIAS_W       = BIAS_W_DEF,
    parameter int OUT_W        = OUT_W_DEF,
    parameter int SHIFT        = 2,
    parameter int RELU_EN      = 1,
    parameter int N_BEATS      = 196
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_adder_tree*IN_W-1:0]   in_data,
    input  logic [N_adder_tree*BIAS_W-1:0] bias,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_adder_tree*OUT_W-1:0]  out_data,
    output logic                       out_last,
    output logic                       sat_flag,
    input  logic                       sat_clr
);

    localparam int SUM_W = sum_width(IN_W, BIAS_W);
    localparam int CNT_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BEATS - 1);

    logic                             v1_r;
    logic [N_adder_tree*SUM_W-1:0]    s1_r;
    logic                             sat2_r;
    logic [CNT_W-1:0]                 cnt_r;
    logic [N_adder_tree*SUM_W-1:0]    sum_s;
    logic [N_adder_tree*OUT_W-1:0]    q_s;
    logic [N_adder_tree-1:0]          sat_lane_s;
    logic                             adv2_s;
    logic                             out_xfer_s;

    assign adv2_s     = !out_valid | out_ready;
    assign in_ready   = !v1_r | adv2_s;
    assign out_xfer_s = out_valid & out_ready;
    assign out_last   = out_valid & (cnt_r == LAST_CNT);

    for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
        requant_lane #(
            .IN_W    (IN_W),
            .BIAS_W  (BIAS_W),
            .OUT_W   (OUT_W),
            .SHIFT   (SHIFT),
            .RELU_EN (RELU_EN),
            .SUM_W   (SUM_W)
        ) u_lane (
            .in_word   (in_data[lane_lsb(IN_W, i) +: IN_W]),
            .bias_word (bias[lane_lsb(BIAS_W, i) +: BIAS_W]),
            .sum       (sum_s[lane_lsb(SUM_W, i) +: SUM_W]),
            .sum_q     (s1_r[lane_lsb(SUM_W, i) +: SUM_W]),
            .q         (q_s[lane_lsb(OUT_W, i) +: OUT_W]),
            .sat       (sat_lane_s[i])
        );
    end

    // Stage 1: capture biased sums whenever the stage can move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r <= 1'b0;
            s1_r <= '0;
        end else if (in_ready) begin
            v1_r <= in_valid;
            if (in_valid) begin
                s1_r <= sum_s;
            end
        end
    end

    // Stage 2: requantised outputs, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            sat2_r    <= 1'b0;
        end else if (adv2_s) begin
            out_valid <= v1_r;
            if (v1_r) begin
                out_data <= q_s;
                sat2_r   <= |sat_lane_s;
            end
        end
    end

    // Beat position within the feature map, advanced per output transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (out_xfer_s) begin
            cnt_r <= (cnt_r == LAST_CNT) ? '0 : cnt_r + CNT_W'(1);
        end
    end

    // Sticky saturation flag; a clear wins over a same-cycle set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (sat_clr) begin
            sat_flag <= 1'b0;
        end else if (out_xfer_s & sat2_r) begin
            sat_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bias_relu_requant.sv
// Directed and streamed checks of bias_relu_requant with ReLU on and off.
module tb_bias_relu_requant;

    localparam int N       = 16;
    localparam int IN_W    = 18;
    localparam int BIAS_W  = 18;
    localparam int OUT_W   = 16;
    localparam int N_BEATS = 196;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid, out_ready, sat_clr;
    logic [N*IN_W-1:0]   in_data;
    logic [N*BIAS_W-1:0] bias;

    logic in_ready_r, out_valid_r, out_last_r, sat_flag_r;
    logic in_ready_n, out_valid_n, out_last_n, sat_flag_n;
    logic [N*OUT_W-1:0] out_data_r, out_data_n;

    int checks = 0;
    int failures = 0;

    int bias_tab[N] = '{5684, -4456, 2271, 1000, -1, 7, 6, 5,
                        130000, -130000, 3, 2, 1, 100, 401, 402};
    int exp_tab[N]  = '{1421, 0, 568, 250, 0, 2, 2, 1,
                        32500, 0, 1, 1, 0, 25, 100, 101};

    always #5 clk = ~clk;

    bias_relu_requant #(.N_adder_tree(N), .RELU_EN(1), .N_BEATS(N_BEATS)) dut_r (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r),
        .in_data(in_data), .bias(bias), .out_valid(out_valid_r), .out_ready(out_ready),
        .out_data(out_data_r), .out_last(out_last_r), .sat_flag(sat_flag_r), .sat_clr(sat_clr)
    );

    bias_relu_requant #(.N_adder_tree(N), .RELU_EN(0), .N_BEATS(N_BEATS)) dut_n (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_data(in_data), .bias(bias), .out_valid(out_valid_n), .out_ready(out_ready),
        .out_data(out_data_n), .out_last(out_last_n), .sat_flag(sat_flag_n), .sat_clr(sat_clr)
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference for the ReLU-enabled instance: floor((s+2)/4), saturated to 16 bits.
    function automatic logic [N*OUT_W-1:0] model(input logic [N*IN_W-1:0] d,
                                                 input logic [N*BIAS_W-1:0] b);
        logic [N*OUT_W-1:0] o;
        int s, r;
        o = '0;
        for (int i = 0; i < N; i++) begin
            s = int'(signed'(d[i*IN_W +: IN_W])) + int'(signed'(b[i*BIAS_W +: BIAS_W]));
            if (s < 0) s = 0;
            r = (s + 2) >>> 2;
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
            o[i*OUT_W +: OUT_W] = 16'(r);
        end
        return o;
    endfunction

    task automatic send_one(input logic [N*IN_W-1:0] d);
        @(negedge clk);
        in_data = d;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("lat_1cyc", out_valid_r, 1'b0);
        @(posedge clk); #1;
        check_eq("lat_2cyc", out_valid_r, 1'b1);
    endtask

    task automatic run_stream(input int nbeats);
        logic [N*OUT_W-1:0] exp_q[$];
        logic [N*IN_W-1:0]  d;
        int sent = 0;
        int got = 0;
        int occ = 0;
        int cyc = 0;
        bit pending = 1'b0;
        d = '0;
        while ((got < nbeats) && (cyc < 20000)) begin
            @(negedge clk);
            cyc++;
            if (!pending && (sent < nbeats)) begin
                for (int i = 0; i < N; i++) d[i*IN_W +: IN_W] = 18'($urandom);
                pending = ($urandom_range(0, 3) != 32'd0);
            end
            in_valid  = pending;
            in_data   = d;
            out_ready = $urandom_range(0, 1) != 32'd0;
            #1;
            if ((occ == 2) && !out_ready) check_eq("full_stall", in_ready_r, 1'b0);
            if (out_valid_r && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("stream_spurious", out_valid_r, 1'b0);
                end else begin
                    check_eq("stream_data", out_data_r, exp_q.pop_front());
                end
                check_eq("stream_last", out_last_r, (got % N_BEATS) == (N_BEATS - 1));
                got++;
                occ--;
            end
            if (in_valid && in_ready_r) begin
                exp_q.push_back(model(d, bias));
                sent++;
                occ++;
                pending = 1'b0;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("stream_count", got, nbeats);
    endtask

    initial begin
        logic [N*IN_W-1:0]  d;
        logic [N*OUT_W-1:0] exp_vec;
        in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
        in_data = '0; bias = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", out_valid_r, 1'b0);
        check_eq("rst_data", out_data_r, '0);
        check_eq("rst_last", out_last_r, 1'b0);
        check_eq("rst_sat", sat_flag_r, 1'b0);
        check_eq("rst_ready", in_ready_r, 1'b1);
        check_eq("rst_ready_n", in_ready_n, 1'b1);
        check_eq("rst_last_n", out_last_n, 1'b0);
        check_eq("rst_valid_n", out_valid_n, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        // 100 + 50 = 150 -> (150+2)>>2 = 38
        d = '0; d[17:0] = 18'd100;
        bias = '0; bias[17:0] = 18'd50;
        send_one(d);
        check_eq("basic_r", out_data_r[15:0], 16'd38);
        check_eq("basic_n", out_data_n[15:0], 16'd38);
        @(posedge clk); #1;
        check_eq("basic_nosat", sat_flag_r, 1'b0);

        // -300 + 100 = -200
        d = '0; d[17:0] = 18'h3FED4;
        bias = '0; bias[17:0] = 18'd100;
        send_one(d);
        check_eq("neg_relu", out_data_r[15:0], 16'd0);
        check_eq("neg_norelu", out_data_n[15:0], 16'hFFCE);

        // -6 -> (-4)>>>2 = -1
        d = '0; d[17:0] = 18'h3FFFA;
        bias = '0;
        send_one(d);
        check_eq("round_relu", out_data_r[15:0], 16'd0);
        check_eq("round_half_up", out_data_n[15:0], 16'hFFFF);

        // positive saturation, then sticky flag and clear
        d = '0; d[17:0] = 18'h1FFFF;
        bias = '0; bias[17:0] = 18'h1FFFF;
        send_one(d);
        check_eq("sat_pos_r", out_data_r[15:0], 16'h7FFF);
        check_eq("sat_pos_n", out_data_n[15:0], 16'h7FFF);
        @(posedge clk); #1;
        check_eq("sat_flag_set", sat_flag_r, 1'b1);
        @(negedge clk) sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        check_eq("sat_flag_clr", sat_flag_r, 1'b0);
        check_eq("sat_flag_clr_n", sat_flag_n, 1'b0);

        // negative saturation only without ReLU
        d = '0; d[17:0] = 18'h20000;
        bias = '0; bias[17:0] = 18'h20000;
        send_one(d);
        check_eq("sat_neg_r", out_data_r[15:0], 16'd0);
        check_eq("sat_neg_n", out_data_n[15:0], 16'h8000);
        @(posedge clk); #1;
        check_eq("sat_neg_flag_n", sat_flag_n, 1'b1);
        check_eq("sat_neg_flag_r", sat_flag_r, 1'b0);

        // lane packing: in=0, distinct biases
        exp_vec = '0;
        for (int i = 0; i < N; i++) begin
            bias[i*BIAS_W +: BIAS_W] = 18'(bias_tab[i]);
            exp_vec[i*OUT_W +: OUT_W] = 16'(exp_tab[i]);
        end
        send_one('0);
        check_eq("lanes_r", out_data_r, exp_vec);
        check_eq("lane1_n", out_data_n[1*OUT_W +: OUT_W], 16'hFBA6);
        check_eq("lane4_n", out_data_n[4*OUT_W +: OUT_W], 16'h0000);
        check_eq("lane9_n", out_data_n[9*OUT_W +: OUT_W], 16'h810C);

        // fresh counter for the long stream
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        run_stream(3 * N_BEATS);

        // two beats in flight, then an asynchronous reset
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = '0; in_data[17:0] = 18'd400;
        @(posedge clk);
        @(negedge clk);
        in_data[17:0] = 18'd800;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_eq("inflight_valid", out_valid_r, 1'b1);
        check_eq("inflight_full", in_ready_r, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", out_valid_r, 1'b0);
        check_eq("midrst_data", out_data_r, '0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        run_stream(N_BEATS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
